// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, FSM encodings and helpers for the AXIS test-packet generator.
package axis_pkt_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // PRBS-31, x^31 + x^28 + 1
    localparam logic [30:0] PRBS_SEED   = 31'h7FFF_FFFF;
    localparam int          PRBS_TAP_HI = 30;
    localparam int          PRBS_TAP_LO = 27;

    // Descriptor of the beat on the bus, or of the next beat to be loaded
    typedef struct packed {
        logic [15:0] seq;
        logic [15:0] len;
        logic [15:0] idx;
    } beat_t;

    // MSB-first byte enables: the top rem lanes are set, rem = 0 means full
    function automatic logic [255:0] keep_msb(input int unsigned rem, input int unsigned kb);
        keep_msb = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (i < kb && (rem == 0 || i >= kb - rem))
                keep_msb[i] = 1'b1;
        end
    endfunction

    function automatic logic [30:0] prbs31_step(input logic [30:0] s);
        return {s[29:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle carrying the generator's packets to a sink.
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int KB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KB-1:0]         tkeep;
    logic                  tlast;
    logic [31:0]           tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_gen_len_ctrl.sv
// Length sweep step, beat count, last-beat detect and tkeep for a beat descriptor.
module axis_pkt_gen_len_ctrl
    import axis_pkt_gen_pkg::*;
#(
    parameter int          P_DATA_WIDTH = 64,
    parameter logic [15:0] P_MIN_LEN    = 16'd60,
    parameter logic [15:0] P_MAX_LEN    = 16'd1514
) (
    input  logic [15:0]                 i_cur_len,
    output logic [15:0]                 o_next_len,
    input  logic [15:0]                 i_beat_len,
    input  logic [15:0]                 i_beat_idx,
    output logic                        o_last,
    output logic [P_DATA_WIDTH/8-1:0]   o_keep
);
    localparam int          KB   = P_DATA_WIDTH / 8;
    localparam logic [15:0] KB16 = 16'(KB);

    logic [15:0] rem;
    logic [15:0] beats;

    always_comb begin
        o_next_len = (i_cur_len >= P_MAX_LEN) ? P_MIN_LEN : i_cur_len + 16'd1;
        rem        = i_beat_len % KB16;
        // Written as quotient + carry so a length near 16'hFFFF cannot overflow
        beats      = i_beat_len / KB16 + {15'd0, |rem};
        o_last     = (i_beat_idx == beats);
        o_keep     = o_last ? KB'(keep_msb(32'(rem), KB)) : '1;
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream test-packet generator: FSM and registered AXIS outputs.
// Optional PRBS-31 payload is built when AXIS_PKT_GEN_PRBS_EN is defined.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int          P_DATA_WIDTH  = 64,
    parameter logic [15:0] P_MIN_LEN     = 16'd60,
    parameter logic [15:0] P_MAX_LEN     = 16'd1514,
    parameter logic [15:0] P_PKT_NUM     = 16'd20,
    parameter logic [7:0]  P_GAP_CYCLES  = 8'd4,
    parameter logic [11:0] P_INIT_CYCLES = 12'd4095
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
`ifdef AXIS_PKT_GEN_PRBS_EN
    input  logic        i_prbs_mode,
`endif
    output logic        o_busy,
    output logic [15:0] o_pkt_cnt,
    axis_pkt_gen_if.master m_axis
);
    localparam int KB    = P_DATA_WIDTH / 8;
    localparam int NLANE = P_DATA_WIDTH / 16;

    logic [1:0]              state_q, state_d;
    logic [11:0]             init_cnt_q, init_cnt_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic [15:0]             pkt_cnt_q, pkt_cnt_d, pkt_cnt_inc;
    logic                    stop_pend_q, stop_pend_d;
    logic                    busy_q, busy_d;
    beat_t                   cur_q, cur_d, nxt;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [P_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KB-1:0]           tkeep_q, tkeep_d;
    logic [31:0]             tuser_q, tuser_d;
`ifdef AXIS_PKT_GEN_PRBS_EN
    logic [30:0]             prbs_q, prbs_d;
    logic                    prbs_mode_q, prbs_mode_d;
`endif
    logic                    accept, do_load, pkt_done;
    logic [15:0]             next_len;
    logic                    nxt_last;
    logic [KB-1:0]           nxt_keep;

    axis_pkt_gen_len_ctrl #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_MIN_LEN    (P_MIN_LEN),
        .P_MAX_LEN    (P_MAX_LEN)
    ) u_len_ctrl (
        .i_cur_len  (cur_q.len),
        .o_next_len (next_len),
        .i_beat_len (nxt.len),
        .i_beat_idx (nxt.idx),
        .o_last     (nxt_last),
        .o_keep     (nxt_keep)
    );

    // In SEND the next beat follows the one on the bus; elsewhere cur_q is already it
    always_comb begin
        nxt = cur_q;
        if (state_q == ST_SEND) begin
            if (tlast_q) begin
                nxt.seq = cur_q.seq + 16'd1;
                nxt.len = next_len;
                nxt.idx = 16'd1;
            end else begin
                nxt.idx = cur_q.idx + 16'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        stop_pend_d = stop_pend_q;
        cur_d       = cur_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tuser_d     = tuser_q;
`ifdef AXIS_PKT_GEN_PRBS_EN
        prbs_d      = prbs_q;
        prbs_mode_d = prbs_mode_q;
`endif
        accept      = tvalid_q & m_axis.tready;
        do_load     = 1'b0;
        pkt_cnt_inc = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
        pkt_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = P_INIT_CYCLES;
                    pkt_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                    cur_d.seq   = '0;
                    cur_d.len   = P_MIN_LEN;
                    cur_d.idx   = 16'd1;
`ifdef AXIS_PKT_GEN_PRBS_EN
                    prbs_d      = PRBS_SEED;
                    prbs_mode_d = i_prbs_mode;
`endif
                end
            end
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = ST_SEND;
                    do_load = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q - 12'd1;
                end
            end
            ST_SEND: begin
                stop_pend_d = stop_pend_q | i_stop;
                if (accept) begin
`ifdef AXIS_PKT_GEN_PRBS_EN
                    prbs_d = prbs31_step(prbs_q);
`endif
                    if (!tlast_q) begin
                        do_load = 1'b1;
                    end else begin
                        pkt_cnt_d = pkt_cnt_inc;
                        pkt_done  = (P_PKT_NUM != 16'd0 && pkt_cnt_inc == P_PKT_NUM)
                                    || stop_pend_q || i_stop;
                        if (pkt_done) begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end else if (P_GAP_CYCLES == 8'd0) begin
                            do_load = 1'b1;
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = 8'(P_GAP_CYCLES - 8'd1);
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            cur_d     = nxt;
                        end
                    end
                end
            end
            default: begin  // ST_GAP
                if (i_stop || stop_pend_q) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = ST_SEND;
                    do_load = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
        endcase

        if (do_load) begin
            cur_d    = nxt;
            tvalid_d = 1'b1;
            tlast_d  = nxt_last;
            tkeep_d  = nxt_keep;
            tuser_d  = {nxt.seq, nxt.len};
            for (int i = 0; i < NLANE; i++) begin
                tdata_d[i*16 +: 16] = nxt.idx;
`ifdef AXIS_PKT_GEN_PRBS_EN
                // 32-bit word {1'b0, prbs} replicated, low half in even lanes
                if (prbs_mode_q)
                    tdata_d[i*16 +: 16] = (i % 2 == 1) ? {1'b0, prbs_d[30:16]} : prbs_d[15:0];
`endif
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            init_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            cur_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '1;
            tuser_q     <= '0;
`ifdef AXIS_PKT_GEN_PRBS_EN
            prbs_q      <= PRBS_SEED;
            prbs_mode_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            cur_q       <= cur_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
`ifdef AXIS_PKT_GEN_PRBS_EN
            prbs_q      <= prbs_d;
            prbs_mode_q <= prbs_mode_d;
`endif
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign o_busy        = busy_q;
    assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: default-parameter instance plus a short
// wrap/back-to-back instance, checked against hand-derived packet tables.
module tb_axis_pkt_gen;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] user;
    } beat_s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, stop = 1'b0, tready = 1'b1;
    logic        prbs_mode = 1'b0;
    logic        busy0, busy1;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    axis_pkt_gen_if #(.DATA_WIDTH(64)) ax0 ();
    axis_pkt_gen_if #(.DATA_WIDTH(64)) ax1 ();
    assign ax0.tready = tready;
    assign ax1.tready = tready;

    axis_pkt_gen dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_stop(stop),
`ifdef AXIS_PKT_GEN_PRBS_EN
        .i_prbs_mode(prbs_mode),
`endif
        .o_busy(busy0), .o_pkt_cnt(cnt0), .m_axis(ax0)
    );

    axis_pkt_gen #(
        .P_MIN_LEN(16'd8), .P_MAX_LEN(16'd10), .P_PKT_NUM(16'd6),
        .P_GAP_CYCLES(8'd0), .P_INIT_CYCLES(12'd2)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_stop(stop),
`ifdef AXIS_PKT_GEN_PRBS_EN
        .i_prbs_mode(1'b0),
`endif
        .o_busy(busy1), .o_pkt_cnt(cnt1), .m_axis(ax1)
    );

    logic  mon_sel = 1'b0;
    logic  mon_valid, mon_busy;
    beat_s mon_beat;
    always_comb begin
        if (mon_sel) begin
            mon_valid = ax1.tvalid; mon_busy = busy1;
            mon_beat  = {ax1.tdata, ax1.tkeep, ax1.tlast, ax1.tuser};
        end else begin
            mon_valid = ax0.tvalid; mon_busy = busy0;
            mon_beat  = {ax0.tdata, ax0.tkeep, ax0.tlast, ax0.tuser};
        end
    end

    int    vecs = 0, errs = 0;
    beat_s got[$], ref_beats[$], exp_q[$];
    int    gaps[$];
    int    first_k, stall_err;
    bit    timeout;

    task automatic start_run(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    // Records accepted beats, idle gaps after each tlast and stall violations.
    task automatic collect(input bit rnd, input int stop_pkt, input int max_cyc);
        beat_s prev = '0;
        bit    prev_stall = 0, after_last = 0;
        int    idle = 0, pkts = 0;
        got.delete(); gaps.delete();
        first_k = -1; stall_err = 0; timeout = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk); @(negedge clk);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (!mon_valid || mon_beat != prev)) stall_err++;
            if (mon_valid && first_k < 0) first_k = k;
            if (after_last && mon_valid) begin gaps.push_back(idle); after_last = 0; end
            else if (after_last) idle++;
            prev_stall = mon_valid && !tready;
            prev       = mon_beat;
            if (mon_valid && tready) begin
                got.push_back(mon_beat);
                if (mon_beat.last) begin pkts++; after_last = 1; idle = 0; end
                else if (pkts == stop_pkt) stop = 1'b1;
            end
            if (!mon_busy) begin tready = 1'b1; return; end
        end
        timeout = 1; tready = 1'b1;
    endtask

    task automatic build_exp(input int min_len, input int max_len, input int npk);
        beat_s e;
        int    len, nb, rem;
        exp_q.delete();
        for (int p = 0; p < npk; p++) begin
            len = min_len + p % (max_len - min_len + 1);
            nb  = (len + 7) / 8;
            rem = len % 8;
            for (int b = 1; b <= nb; b++) begin
                e.data = {4{16'(b)}};
                e.last = (b == nb);
                e.keep = (!e.last || rem == 0) ? 8'hFF : 8'(((1 << rem) - 1) << (8 - rem));
                e.user = {16'(p), 16'(len)};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vecs++; if (ax0.tvalid !== 1'b0) begin errs++; $display("FAIL rst_tvalid got %b want 0", ax0.tvalid); end
        vecs++; if (ax0.tlast !== 1'b0) begin errs++; $display("FAIL rst_tlast got %b want 0", ax0.tlast); end
        vecs++; if (ax0.tkeep !== 8'hFF) begin errs++; $display("FAIL rst_tkeep got %h want ff", ax0.tkeep); end
        vecs++; if (ax0.tdata !== 64'd0) begin errs++; $display("FAIL rst_tdata got %h want 0", ax0.tdata); end
        vecs++; if (ax0.tuser !== 32'd0) begin errs++; $display("FAIL rst_tuser got %h want 0", ax0.tuser); end
        vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy0); end
        vecs++; if (cnt0 !== 16'd0) begin errs++; $display("FAIL rst_pkt_cnt got %0d want 0", cnt0); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (ax0.tvalid !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL idle_after_rst tvalid %b busy %b want 0 0", ax0.tvalid, busy0); end
    endtask

    task automatic test_default_run();
        int bad = 0;
        mon_sel = 1'b0;
        build_exp(60, 1514, 20);
        start_run(0);
        collect(0, -1, 6000);
        vecs++; if (timeout) begin errs++; $display("FAIL basic_timeout got busy stuck want idle"); end
        vecs++; if (first_k !== 4096) begin errs++; $display("FAIL basic_first_valid got %0d want 4096", first_k); end
        vecs++; if (got.size() !== exp_q.size()) begin errs++; $display("FAIL basic_beat_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errs++;
                $display("FAIL basic_beat[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        vecs++; if (got[7].keep !== 8'hF0 || got[7].last !== 1'b1) begin errs++; $display("FAIL pkt0_last_keep got %h/%b want f0/1", got[7].keep, got[7].last); end
        foreach (gaps[i]) if (gaps[i] != 4) bad++;
        vecs++; if (gaps.size() != 19 || bad != 0) begin errs++; $display("FAIL basic_gaps got %0d gaps %0d bad want 19 gaps 0 bad", gaps.size(), bad); end
        vecs++; if (cnt0 !== 16'd20) begin errs++; $display("FAIL basic_pkt_cnt got %0d want 20", cnt0); end
        vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL basic_busy_end got %b want 0", busy0); end
        ref_beats = got;
    endtask

    task automatic test_random_ready();
        int bad = 0;
        mon_sel = 1'b0;
        start_run(0);
        collect(1, -1, 20000);
        vecs++; if (timeout) begin errs++; $display("FAIL rnd_timeout got busy stuck want idle"); end
        vecs++; if (got.size() != ref_beats.size()) begin errs++; $display("FAIL rnd_beat_count got %0d want %0d", got.size(), ref_beats.size()); end
        foreach (ref_beats[i]) if (i >= got.size() || got[i] !== ref_beats[i]) bad++;
        vecs++; if (bad != 0) begin errs++; $display("FAIL rnd_beats got %0d differing beats want 0", bad); end
        vecs++; if (stall_err != 0) begin errs++; $display("FAIL rnd_stall_hold got %0d changes want 0", stall_err); end
        vecs++; if (cnt0 !== 16'd20) begin errs++; $display("FAIL rnd_pkt_cnt got %0d want 20", cnt0); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        mon_sel = 1'b1;
        build_exp(8, 10, 6);
        start_run(1);
        collect(0, -1, 200);
        vecs++; if (timeout) begin errs++; $display("FAIL b2b_timeout got busy stuck want idle"); end
        vecs++; if (first_k !== 3) begin errs++; $display("FAIL b2b_first_valid got %0d want 3", first_k); end
        vecs++; if (got.size() !== 10) begin errs++; $display("FAIL b2b_beat_count got %0d want 10", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errs++;
                $display("FAIL b2b_beat[%0d] got %h want %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        vecs++; if (got[0].keep !== 8'hFF || got[0].last !== 1'b1) begin errs++; $display("FAIL b2b_one_beat got %h/%b want ff/1", got[0].keep, got[0].last); end
        vecs++; if (got[2].keep !== 8'h80) begin errs++; $display("FAIL b2b_len9_keep got %h want 80", got[2].keep); end
        vecs++; if (got[4].keep !== 8'hC0) begin errs++; $display("FAIL b2b_len10_keep got %h want c0", got[4].keep); end
        vecs++; if (got[9].user !== {16'd5, 16'd10}) begin errs++; $display("FAIL b2b_last_user got %h want 0005000a", got[9].user); end
        foreach (gaps[i]) if (gaps[i] != 0) bad++;
        vecs++; if (gaps.size() != 5 || bad != 0) begin errs++; $display("FAIL b2b_gaps got %0d gaps %0d bad want 5 gaps 0 bad", gaps.size(), bad); end
        vecs++; if (cnt1 !== 16'd6) begin errs++; $display("FAIL b2b_pkt_cnt got %0d want 6", cnt1); end
    endtask

    task automatic test_stop();
        mon_sel = 1'b0;
        start_run(0);
        collect(0, 3, 6000);
        stop = 1'b0;
        vecs++; if (timeout) begin errs++; $display("FAIL stop_timeout got busy stuck want idle"); end
        vecs++; if (got.size() !== 32) begin errs++; $display("FAIL stop_beat_count got %0d want 32", got.size()); end
        vecs++; if (got[31].last !== 1'b1 || got[31].user !== {16'd3, 16'd63}) begin errs++; $display("FAIL stop_final_beat got %b/%h want 1/0003003f", got[31].last, got[31].user); end
        vecs++; if (cnt0 !== 16'd4) begin errs++; $display("FAIL stop_pkt_cnt got %0d want 4", cnt0); end
        vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL stop_busy got %b want 0", busy0); end
    endtask

    task automatic test_reset_mid_packet();
        bit found = 0;
        mon_sel = 1'b0;
        start_run(0);
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (ax0.tvalid && ax0.tdata[15:0] == 16'd5) begin found = 1; break; end
        end
        vecs++; if (!found) begin errs++; $display("FAIL rstmid_reach_beat5 got timeout want beat 5"); end
        rst = 1'b1;
        #1;
        vecs++; if (ax0.tvalid !== 1'b0) begin errs++; $display("FAIL rstmid_tvalid got %b want 0", ax0.tvalid); end
        vecs++; if (ax0.tkeep !== 8'hFF || ax0.tlast !== 1'b0) begin errs++; $display("FAIL rstmid_keep_last got %h/%b want ff/0", ax0.tkeep, ax0.tlast); end
        vecs++; if (busy0 !== 1'b0 || cnt0 !== 16'd0) begin errs++; $display("FAIL rstmid_busy_cnt got %b/%0d want 0/0", busy0, cnt0); end
        @(negedge clk);
        rst = 1'b0;
        start_run(0);
        collect(0, -1, 6000);
        vecs++; if (got[0].user !== {16'd0, 16'd60} || got[0].data !== {4{16'd1}}) begin errs++; $display("FAIL rstmid_restart got %h/%h want 0000003c/0001000100010001", got[0].user, got[0].data); end
        vecs++; if (cnt0 !== 16'd20) begin errs++; $display("FAIL rstmid_pkt_cnt got %0d want 20", cnt0); end
    endtask

`ifdef AXIS_PKT_GEN_PRBS_EN
    task automatic test_prbs();
        logic [30:0] s = 31'h7FFF_FFFF;
        int bad = 0;
        mon_sel = 1'b0;
        prbs_mode = 1'b1;
        start_run(0);
        prbs_mode = 1'b0;
        collect(0, -1, 6000);
        vecs++; if (got[0].data !== 64'h7FFF_FFFF_7FFF_FFFF) begin errs++; $display("FAIL prbs_first got %h want 7fffffff7fffffff", got[0].data); end
        foreach (got[i]) begin
            if (got[i].data !== {2{1'b0, s}}) bad++;
            s = {s[29:0], s[30] ^ s[27]};
        end
        vecs++; if (bad != 0 || got.size() == 0) begin errs++; $display("FAIL prbs_seq got %0d bad of %0d want 0 bad", bad, got.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_random_ready();
        test_back_to_back();
        test_stop();
        test_reset_mid_packet();
`ifdef AXIS_PKT_GEN_PRBS_EN
        test_prbs();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
